// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and op-decode helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } state_t;

  function automatic logic op_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation: absolute value on operand entry, sign restore on result exit.
module muldiv_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] val,
  input  logic             neg,
  output logic [WIDTH-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply (radix-2 shift-add) and divide (restoring), one bit per cycle.
// done pulses WIDTH+1 edges after the start-sampling edge; start is ignored while busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      op_q;
  // acc: partial-product upper half / partial remainder; shf: multiplier / dividend->quotient
  logic [WIDTH-1:0] acc, shf, opb;
  logic            neg_lo, neg_hi;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   add_sum, div_try, div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign a_neg = op_signed(op) & in_a[WIDTH-1];
  assign b_neg = op_signed(op) & in_b[WIDTH-1];

  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_a (.val(in_a), .neg(a_neg), .res(abs_a));
  muldiv_signfix #(.WIDTH(WIDTH)) u_abs_b (.val(in_b), .neg(b_neg), .res(abs_b));

  muldiv_signfix #(.WIDTH(2*WIDTH)) u_fix_prod (.val({acc, shf}), .neg(neg_lo), .res(prod_fix));
  muldiv_signfix #(.WIDTH(WIDTH))   u_fix_quo  (.val(shf),        .neg(neg_lo), .res(quo_fix));
  muldiv_signfix #(.WIDTH(WIDTH))   u_fix_rem  (.val(acc),        .neg(neg_hi), .res(rem_fix));

  assign add_sum = {1'b0, acc} + (shf[0] ? {1'b0, opb} : '0);
  assign div_try = {acc, shf[WIDTH-1]};
  assign div_sub = div_try - {1'b0, opb};

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= OP_MULT;
      acc    <= '0;
      shf    <= '0;
      opb    <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIXUP);
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            acc    <= '0;
            shf    <= abs_a;
            opb    <= abs_b;
            cnt    <= '0;
            // Divide by zero keeps the all-ones quotient un-negated; remainder then restores in_a.
            neg_lo <= (a_neg ^ b_neg) & (|in_b);
            neg_hi <= a_neg;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (op_is_div(op_q)) begin
            if (!div_sub[WIDTH]) begin
              acc <= div_sub[WIDTH-1:0];
              shf <= {shf[WIDTH-2:0], 1'b1};
            end else begin
              acc <= div_try[WIDTH-1:0];
              shf <= {shf[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc <= add_sum[WIDTH:1];
            shf <= {add_sum[0], shf[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          if (op_is_div(op_q)) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
